// File: rtl/riscv_pkg.sv
// Shared pipeline types for hazard detection and operand forwarding.
package riscv_pkg;

    localparam int unsigned REG_ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        FWD_NONE   = 2'b00,
        FWD_MEM_WB = 2'b01,
        FWD_EX_MEM = 2'b10
    } fwd_sel_t;

    // Stage shadow record at the default register-index width.
    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_W_DEF-1:0] rs1;
        logic [REG_ADDR_W_DEF-1:0] rs2;
        logic [REG_ADDR_W_DEF-1:0] rd;
        logic                      regwrite;
        logic                      memread;
    } stage_rec_t;

endpackage

// File: rtl/fwd_match.sv
// Forward-select for one EX operand; the younger EX/MEM producer beats MEM/WB.
module fwd_match
    import riscv_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  mem_valid,
    input  logic                  mem_regwrite,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_valid,
    input  logic                  wb_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output fwd_sel_t              sel
);

    logic mem_hit;
    logic wb_hit;

    // x0 is hardwired zero, so a zero source index never matches a producer.
    assign mem_hit = mem_valid && mem_regwrite && (mem_rd == src) && (src != '0);
    assign wb_hit  = wb_valid && wb_regwrite && (wb_rd == src) && (src != '0);

    always_comb begin
        sel = FWD_NONE;
        if (ex_valid) begin
            if (mem_hit) begin
                sel = FWD_EX_MEM;
            end else if (wb_hit) begin
                sel = FWD_MEM_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Load-use stall, branch flush and EX operand forwarding control for a
// classic five-stage pipeline, tracked via shadow EX/MEM/WB records.
module hazard_forward_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_regwrite_i,
    input  logic                  id_memread_i,
    input  logic                  branch_taken_i,
    output logic [1:0]            forward_a_o,
    output logic [1:0]            forward_b_o,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic [CNT_W-1:0]      stall_count_o
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
    } ex_rec_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
    } pipe_rec_t;

    ex_rec_t    ex_q, ex_d;
    pipe_rec_t  mem_q, mem_d;
    pipe_rec_t  wb_q, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic     load_use_c;
    logic     stall_c;
    fwd_sel_t sel_a;
    fwd_sel_t sel_b;

    // Load in EX whose result an ID source needs next cycle; a taken branch wins.
    assign load_use_c = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && id_valid_i &&
                        ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i));
    assign stall_c    = load_use_c && !branch_taken_i;

    assign stall_o       = stall_c;
    assign flush_o       = branch_taken_i;
    assign stall_count_o = cnt_q;

    // Stage advance: a stalled or flushed ID slot enters EX as a bubble.
    always_comb begin
        ex_d  = '0;
        mem_d = '0;
        wb_d  = '0;
        cnt_d = cnt_q;

        if (id_valid_i && !stall_c && !branch_taken_i) begin
            ex_d.valid    = 1'b1;
            ex_d.rs1      = id_rs1_i;
            ex_d.rs2      = id_rs2_i;
            ex_d.rd       = id_rd_i;
            ex_d.regwrite = id_regwrite_i;
            ex_d.memread  = id_memread_i;
        end

        mem_d.valid    = ex_q.valid;
        mem_d.rd       = ex_q.rd;
        mem_d.regwrite = ex_q.regwrite;
        wb_d           = mem_q;

        if (stall_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    fwd_match #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_a (
        .ex_valid     (ex_q.valid),
        .src          (ex_q.rs1),
        .mem_valid    (mem_q.valid),
        .mem_regwrite (mem_q.regwrite),
        .mem_rd       (mem_q.rd),
        .wb_valid     (wb_q.valid),
        .wb_regwrite  (wb_q.regwrite),
        .wb_rd        (wb_q.rd),
        .sel          (sel_a)
    );

    fwd_match #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_b (
        .ex_valid     (ex_q.valid),
        .src          (ex_q.rs2),
        .mem_valid    (mem_q.valid),
        .mem_regwrite (mem_q.regwrite),
        .mem_rd       (mem_q.rd),
        .wb_valid     (wb_q.valid),
        .wb_regwrite  (wb_q.regwrite),
        .wb_rd        (wb_q.rd),
        .sel          (sel_b)
    );

    assign forward_a_o = 2'(sel_a);
    assign forward_b_o = 2'(sel_b);

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench: directed instruction stream with hand-computed per-cycle
// expectations, checked by an independent negedge monitor.
module tb_hazard_forward_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic [AW-1:0] id_rd;
    logic          id_regwrite;
    logic          id_memread;
    logic          branch_taken;
    logic [1:0]    forward_a;
    logic [1:0]    forward_b;
    logic          stall;
    logic          flush;
    logic [CW-1:0] stall_count;

    typedef struct {
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic          st;
        logic          fl;
        logic [CW-1:0] cnt;
        string         name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    hazard_forward_ctrl #(
        .REG_ADDR_W (AW),
        .CNT_W      (CW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .id_valid_i     (id_valid),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_rd_i        (id_rd),
        .id_regwrite_i  (id_regwrite),
        .id_memread_i   (id_memread),
        .branch_taken_i (branch_taken),
        .forward_a_o    (forward_a),
        .forward_b_o    (forward_b),
        .stall_o        (stall),
        .flush_o        (flush),
        .stall_count_o  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs settle after the #1 drive; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (forward_a !== mon_e.fa || forward_b !== mon_e.fb || stall !== mon_e.st ||
                flush !== mon_e.fl || stall_count !== mon_e.cnt) begin
                errors++;
                $display("FAIL %s: got fa=%b fb=%b stall=%b flush=%b cnt=%0d, expected fa=%b fb=%b stall=%b flush=%b cnt=%0d",
                         mon_e.name, forward_a, forward_b, stall, flush, stall_count,
                         mon_e.fa, mon_e.fb, mon_e.st, mon_e.fl, mon_e.cnt);
            end
        end
    end

    // One cycle of ID stimulus plus the outputs expected during that cycle.
    task automatic step(input string name, input int r, input int v, input int rs1, input int rs2,
                        input int rd, input int rw, input int mr, input int br,
                        input int efa, input int efb, input int est, input int efl, input int ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = 1'(r);
        id_valid     = 1'(v);
        id_rs1       = AW'(rs1);
        id_rs2       = AW'(rs2);
        id_rd        = AW'(rd);
        id_regwrite  = 1'(rw);
        id_memread   = 1'(mr);
        branch_taken = 1'(br);
        e.fa   = 2'(efa);
        e.fb   = 2'(efb);
        e.st   = 1'(est);
        e.fl   = 1'(efl);
        e.cnt  = CW'(ecnt);
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst          = 1'b1;
        id_valid     = 1'b0;
        id_rs1       = '0;
        id_rs2       = '0;
        id_rd        = '0;
        id_regwrite  = 1'b0;
        id_memread   = 1'b0;
        branch_taken = 1'b0;
    endtask

    initial begin
        int c;
        int c_next;
        rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_regwrite = 1'b0; id_memread = 1'b0; branch_taken = 1'b0;
        do_reset();

        //    name            rst v rs1 rs2 rd rw mr br   fa fb st fl cnt
        step("post_reset",     0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0);
        // back-to-back RAW through EX/MEM
        step("prod_x5",        0, 1, 1, 2, 5, 1, 0, 0,   0, 0, 0, 0, 0);
        step("cons_x6_id",     0, 1, 5, 1, 6, 1, 0, 0,   0, 0, 0, 0, 0);
        step("exmem_fwd_a",    0, 0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0);
        // producer, independent op, consumer through MEM/WB
        step("prod_x5_b",      0, 1, 1, 2, 5, 1, 0, 0,   0, 0, 0, 0, 0);
        step("indep_x9",       0, 1, 3, 4, 9, 1, 0, 0,   0, 0, 0, 0, 0);
        step("cons_x10_id",    0, 1, 5, 5, 10, 1, 0, 0,  0, 0, 0, 0, 0);
        step("memwb_fwd_ab",   0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
        // intervening op also writes x5: younger producer wins
        step("prod_x5_old",    0, 1, 1, 2, 5, 1, 0, 0,   0, 0, 0, 0, 0);
        step("prod_x5_new",    0, 1, 3, 4, 5, 1, 0, 0,   0, 0, 0, 0, 0);
        step("cons_x11_id",    0, 1, 5, 2, 11, 1, 0, 0,  0, 0, 0, 0, 0);
        step("priority_exmem", 0, 0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0);
        // load-use: one stall, bubble, then MEM/WB forward on rs2
        step("lw_x7",          0, 1, 1, 0, 7, 1, 1, 0,   0, 0, 0, 0, 0);
        step("load_use_stall", 0, 1, 1, 7, 8, 1, 0, 0,   0, 0, 1, 0, 0);
        step("stall_released", 0, 1, 1, 7, 8, 1, 0, 0,   0, 0, 0, 0, 1);
        step("lw_fwd_b",       0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1);
        // taken branch overrides load-use
        step("lw_x7_br",       0, 1, 2, 0, 7, 1, 1, 0,   0, 0, 0, 0, 1);
        step("flush_over",     0, 1, 7, 1, 8, 1, 0, 1,   0, 0, 0, 1, 1);
        step("after_flush",    0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
        // x0 never forwards or stalls
        step("prod_x0",        0, 1, 1, 2, 0, 1, 0, 0,   0, 0, 0, 0, 1);
        step("cons_x0_id",     0, 1, 0, 0, 3, 1, 0, 0,   0, 0, 0, 0, 1);
        step("x0_no_fwd",      0, 1, 1, 0, 0, 1, 1, 0,   0, 0, 0, 0, 1);
        step("lw_x0_no_stall", 0, 1, 0, 0, 4, 1, 0, 0,   0, 0, 0, 0, 1);
        step("x0_wb_no_fwd",   0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);

        // 16 more load-use stalls drive the 4-bit counter into saturation
        c = 1;
        for (int i = 0; i < 16; i++) begin
            c_next = (c == 15) ? 15 : c + 1;
            step("sat_lw",     0, 1, 1, 0, 7, 1, 1, 0,   0, 0, 0, 0, c);
            step("sat_stall",  0, 1, 7, 1, 8, 1, 0, 0,   0, 0, 1, 0, c);
            step("sat_release",0, 1, 7, 1, 8, 1, 0, 0,   0, 0, 0, 0, c_next);
            step("sat_fwd",    0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, c_next);
            c = c_next;
        end

        // reset during a stall cycle discards the in-flight load
        step("pre_rst_lw",     0, 1, 1, 0, 7, 1, 1, 0,   0, 0, 0, 0, 15);
        step("rst_mid_stall",  1, 1, 7, 1, 8, 1, 0, 0,   0, 0, 1, 0, 15);
        step("after_rst",      0, 1, 7, 1, 8, 1, 0, 0,   0, 0, 0, 0, 0);
        step("rst_no_carry",   0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0);
        step("rst_tail",       0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);

        for (int k = 0; k < 5 && exp_q.size() != 0; k++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
